// File: rtl/path_replayer.sv
// Records the maze solver's push/pop traffic as a mirror stack, then replays the
// surviving path in forward order (start to exit), one move per valid/ready handshake.
//
// state   | meaning
// CAPTURE | tracking solver push/pop into the mirror stack
// HOLD    | path frozen after done; waiting for run
// REPLAY  | presenting stored moves oldest-first
// FAILED  | solver gave up; only clear/rst leave this state
module path_replayer #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [1:0]        push_val,
  input  logic              pop,
  input  logic              done,
  input  logic              fail,
  input  logic              run,
  input  logic              move_ready,
  output logic              move_valid,
  output logic [1:0]        move,
  output logic              replay_busy,
  output logic              replay_done,
  output logic              path_found,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {CAPTURE, HOLD, REPLAY, FAILED} state_t;

  localparam logic [ADDR_W:0] SP_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] SP_FULL = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]        move_q, move_d;
  logic              replay_done_q, replay_done_d;
  logic              path_found_q, path_found_d;
  logic              overflow_q, overflow_d;
  logic [1:0]        mem_q [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;
  logic [ADDR_W:0]   sp_dec;
  logic [ADDR_W-1:0] rd_inc;
  logic              rd_last;

  assign sp_dec  = sp_q - SP_ONE;
  assign rd_inc  = rd_ptr_q + ADDR_W'(1);
  assign rd_last = ({1'b0, rd_ptr_q} == sp_dec);

  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    rd_ptr_d      = rd_ptr_q;
    move_d        = move_q;
    replay_done_d = 1'b0;
    path_found_d  = path_found_q;
    overflow_d    = overflow_q;
    wr_en         = 1'b0;
    wr_addr       = sp_q[ADDR_W-1:0];
    wr_data       = push_val;

    case (state_q)
      CAPTURE: begin
        // simultaneous push+pop replaces the top entry rather than growing the stack
        if (push && pop && (sp_q != '0)) begin
          wr_en   = 1'b1;
          wr_addr = sp_dec[ADDR_W-1:0];
        end else if (push) begin
          if (sp_q < SP_FULL) begin
            wr_en = 1'b1;
            sp_d  = sp_q + SP_ONE;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (pop && (sp_q != '0)) begin
          sp_d = sp_dec;
        end

        if (done) begin
          state_d      = HOLD;
          path_found_d = 1'b1;
        end else if (fail) begin
          state_d = FAILED;
        end
      end

      HOLD: begin
        if (run) begin
          if (sp_q == '0) begin
            replay_done_d = 1'b1;
          end else begin
            state_d  = REPLAY;
            rd_ptr_d = '0;
            move_d   = mem_q[0];
          end
        end
      end

      REPLAY: begin
        if (move_ready) begin
          if (rd_last) begin
            state_d       = HOLD;
            replay_done_d = 1'b1;
          end else begin
            rd_ptr_d = rd_inc;
            move_d   = mem_q[rd_inc];
          end
        end
      end

      FAILED: begin
        path_found_d = 1'b0;
      end

      default: begin
        state_d = CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q       <= CAPTURE;
      sp_q          <= '0;
      rd_ptr_q      <= '0;
      move_q        <= 2'b00;
      replay_done_q <= 1'b0;
      path_found_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sp_q          <= sp_d;
      rd_ptr_q      <= rd_ptr_d;
      move_q        <= move_d;
      replay_done_q <= replay_done_d;
      path_found_q  <= path_found_d;
      overflow_q    <= overflow_d;
    end
  end

  // buffer contents are left untouched by reset
  always_ff @(posedge clk) begin
    if (wr_en && !rst && !clear) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign move_valid  = (state_q == REPLAY);
  assign replay_busy = (state_q == REPLAY);
  assign move        = move_q;
  assign replay_done = replay_done_q;
  assign path_found  = path_found_q;
  assign overflow    = overflow_q;
  assign count       = sp_q;

endmodule

// File: tb/tb_path_replayer.sv
// Scoreboarded bench for path_replayer: a queue-based stack model predicts the
// replayed path; a negedge monitor checks every handshake against expectations.
module tb_path_replayer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1, clear = 1'b0, push = 1'b0, pop = 1'b0, done = 1'b0, fail = 1'b0;
  logic run = 1'b0, move_ready = 1'b0;
  logic [1:0] push_val = 2'b00;
  logic move_valid, replay_busy, replay_done, path_found, overflow;
  logic [1:0] move;
  logic [ADDR_W:0] count;

  path_replayer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .push_val(push_val),
    .pop(pop), .done(done), .fail(fail), .run(run), .move_ready(move_ready),
    .move_valid(move_valid), .move(move), .replay_busy(replay_busy),
    .replay_done(replay_done), .path_found(path_found), .overflow(overflow),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int model_q[$];
  int mode;          // 0 capturing, 1 path held, 2 failed
  bit m_ovf, m_pf;
  int hs_count;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: each handshake consumes one expected move
  logic [1:0] prev_move;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    if (move_valid && move_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_move: got move %0d, expected no handshake", move);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("move", move, e);
      end
    end
    if (prev_stall && move_valid && !rst && !clear) check("stall_hold", move, prev_move);
    prev_stall = move_valid && !move_ready;
    prev_move  = move;
  end

  task automatic do_clear(input bit use_rst);
    if (use_rst) rst = 1'b1; else clear = 1'b1;
    push = 0; pop = 0; done = 0; fail = 0; run = 0; move_ready = 0;
    tick();
    rst = 1'b0; clear = 1'b0;
    model_q.delete(); exp_q.delete();
    mode = 0; m_ovf = 0; m_pf = 0;
    check("clr_count", count, 0);
    check("clr_valid", move_valid, 0);
    check("clr_busy", replay_busy, 0);
    check("clr_done", replay_done, 0);
    check("clr_path_found", path_found, 0);
    check("clr_overflow", overflow, 0);
  endtask

  task automatic op(input bit p, input int v, input bit q, input bit d, input bit f);
    push = p; push_val = 2'(v); pop = q; done = d; fail = f;
    tick();
    push = 0; pop = 0; done = 0; fail = 0;
    if (mode == 0) begin
      if (p && q && model_q.size() > 0) model_q[model_q.size()-1] = v & 3;
      else if (p) begin
        if (model_q.size() < DEPTH) model_q.push_back(v & 3);
        else m_ovf = 1;
      end else if (q && model_q.size() > 0) void'(model_q.pop_back());
      if (d) begin mode = 1; m_pf = 1; end
      else if (f) mode = 2;
    end
    check("count", count, model_q.size());
    check("overflow", overflow, m_ovf);
    check("path_found", path_found, m_pf);
  endtask

  task automatic replay(input int stall);
    bit held, got_done, saw_valid, hs;
    int n, cyc, w, limit;
    held = (mode == 1);
    n = model_q.size();
    if (held) foreach (model_q[i]) exp_q.push_back(model_q[i]);
    hs_count = 0;
    limit = held ? 200 : 10;
    run = 1'b1;
    tick();
    run = 1'b0;
    check("run_latency", move_valid, held && n > 0);
    cyc = 0; w = 0; got_done = 0; saw_valid = 0;
    while (cyc < limit) begin
      if (replay_done) begin got_done = 1; break; end
      if (move_valid) saw_valid = 1;
      move_ready = move_valid && (w >= stall);
      hs = move_valid && move_ready;
      tick();
      cyc++;
      if (hs) w = 0; else if (move_valid) w++;
    end
    move_ready = 1'b0;
    check("replay_done_seen", got_done, held);
    if (held) begin
      check("replay_cycles", cyc, n * (stall + 1));
      check("hs_count", hs_count, n);
    end
    check("valid_seen", saw_valid, held && n > 0);
    check("exp_drained", exp_q.size(), 0);
    check("count_after_replay", count, n);
    tick();
    check("done_pulse_width", replay_done, 0);
    check("valid_after_replay", move_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_clear(1);

    // forward order
    do_clear(0);
    op(1, 2, 0, 0, 0); op(1, 1, 0, 0, 0); op(1, 3, 0, 0, 0);
    op(0, 0, 0, 1, 0);
    replay(0);
    replay(0);

    // backtrack
    do_clear(0);
    op(1, 0, 0, 0, 0); op(1, 1, 0, 0, 0); op(1, 2, 0, 0, 0);
    op(0, 0, 1, 0, 0); op(0, 0, 1, 0, 0); op(1, 3, 0, 0, 0);
    op(0, 0, 0, 1, 0);
    replay(0);
    do_clear(0);
    op(1, 2, 0, 0, 0); op(1, 3, 0, 0, 0);
    op(1, 1, 1, 0, 0);
    op(1, 0, 1, 1, 0);
    replay(1);

    // backpressure, replayed twice
    do_clear(0);
    op(1, 1, 0, 0, 0); op(1, 3, 0, 0, 0); op(1, 2, 0, 0, 0);
    op(0, 0, 0, 1, 0);
    replay(4);
    replay(4);

    // empty path, then failed search, then done+fail together
    do_clear(0);
    op(0, 0, 0, 1, 0);
    replay(0);
    do_clear(0);
    op(1, 1, 0, 0, 0);
    op(0, 0, 0, 0, 1);
    op(1, 2, 0, 1, 0);
    replay(0);
    do_clear(0);
    op(1, 2, 0, 1, 1);
    replay(0);

    // overflow truncates to first DEPTH moves
    do_clear(0);
    op(1, 0, 0, 0, 0); op(1, 1, 0, 0, 0); op(1, 2, 0, 0, 0);
    op(1, 3, 0, 0, 0); op(1, 1, 0, 0, 0);
    op(0, 0, 0, 1, 0);
    replay(0);

    // clear mid-replay, then a fresh path lands at buf[0]
    do_clear(0);
    op(1, 2, 0, 0, 0); op(1, 1, 0, 0, 0); op(1, 3, 0, 0, 0);
    op(0, 0, 0, 1, 0);
    exp_q.push_back(2);
    run = 1'b1; move_ready = 1'b1;
    tick();
    run = 1'b0;
    tick();
    move_ready = 1'b0;
    check("mid_valid_before_clear", move_valid, 1);
    check("mid_move_before_clear", move, 1);
    do_clear(0);
    op(1, 0, 0, 0, 0);
    op(0, 0, 0, 1, 0);
    replay(0);

    // randomized sessions
    for (int it = 0; it < 30; it++) begin
      int nops;
      do_clear(0);
      nops = $urandom_range(0, 9);
      for (int k = 0; k < nops; k++) begin
        int r;
        r = $urandom_range(0, 9);
        op((r < 5) || (r == 9), $urandom_range(0, 3), r >= 5, 0, 0);
      end
      if ($urandom_range(0, 5) == 0) op(0, 0, 0, 0, 1);
      else op($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), 1, $urandom_range(0, 1));
      op(1, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), 0);
      replay($urandom_range(0, 2));
      replay($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/path_replayer.md
Name: path_replayer

Overview:
- Downstream consumer of the maze-solver controller.
- Mirrors the solver's move stack: it captures every push and pop pulse, together with the push value, while a search is running.
- Once the solver asserts done, the block replays the surviving path from the start cell to the exit cell. Output is one 2-bit move per valid/ready handshake, feeding the display/motion stage.
- The solver's own stack is LIFO and cannot yield moves in forward order; this block provides that ordering.

Parameters:
- DEPTH, 256, maximum stored moves.
- ADDR_W, 8, pointer width; DEPTH = 2**ADDR_W.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- clear  input  1  start of new search (tied to solver's register/counter reset pulse); synchronous, same effect as rst
- push  input  1  solver push pulse
- push_val  input  2  direction code pushed; passed through unmodified
- pop  input  1  solver pop pulse (backtrack)
- done  input  1  solver found exit (1-cycle pulse)
- fail  input  1  solver exhausted maze (1-cycle pulse)
- run  input  1  replay request
- move_ready  input  1  downstream accepts move
- move_valid  output  1  move holds valid direction
- move  output  2  replayed direction code
- replay_busy  output  1  high in REPLAY
- replay_done  output  1  1-cycle pulse when replay completes
- path_found  output  1  sticky, set on done
- overflow  output  1  sticky, push attempted when full
- count  output  ADDR_W+1  number of stored moves (sp)

Behaviour:
- Reset values (rst or clear), effective at the next edge:
  - state = CAPTURE; sp = 0; rd_ptr = 0.
  - move_valid = 0; move = 2'b00; replay_busy = 0; replay_done = 0; path_found = 0; overflow = 0.
  - Buffer contents are don't-care.
- clear/rst take priority over every other input in every state, including mid-replay. move_valid drops at the next edge with no further handshake.
- States: CAPTURE, HOLD, REPLAY, FAILED.
- CAPTURE:
  - push only: if sp < DEPTH, write buf[sp] = push_val and sp++. Otherwise ignore the push and set overflow.
  - pop only: if sp > 0, sp--. Otherwise ignore.
  - push and pop in the same cycle: if sp > 0, overwrite buf[sp-1] with push_val and leave sp unchanged. If sp == 0, treat as a push only.
  - done -> HOLD and set path_found. A push/pop in the same cycle as done is still applied.
  - fail -> FAILED.
  - If done and fail arrive together, done wins.
- HOLD:
  - push, pop, done and fail are ignored.
  - On run: if sp == 0, pulse replay_done next cycle and stay in HOLD.
  - On run with sp > 0: go to REPLAY with rd_ptr = 0, and register move = buf[0]. move_valid rises in the cycle after run is sampled (latency 1).
- REPLAY:
  - move_valid = 1 and replay_busy = 1.
  - move is stable while move_valid & !move_ready.
  - On handshake (move_valid & move_ready) with rd_ptr < sp-1: rd_ptr++ and move = buf[rd_ptr+1] at the same edge. This gives back-to-back moves, one per cycle, when move_ready is held high.
  - On handshake with rd_ptr == sp-1: go to HOLD, move_valid = 0, and pulse replay_done for 1 cycle.
  - run is ignored during REPLAY.
  - A path may be replayed any number of times.
- FAILED:
  - All inputs except clear/rst are ignored.
  - run produces no move_valid and no replay_done.
  - path_found = 0.
- Overflow: the stored path is truncated to its first DEPTH moves, and a later replay outputs exactly those. Pops after overflow still decrement sp.
- count always equals sp; it is not modified by replay.

Test Plan:
- Forward order: clear; push 2, 1, 3; done; run; move_ready=1 -> move 2, 1, 3 on three consecutive cycles starting 1 cycle after run; replay_done pulses on the cycle after the third handshake; count=3.
- Backtrack: push 0, 1, 2; pop; pop; push 3; done; run -> moves 0, 3 only; count=2. Also push and pop in the same cycle with sp=2 -> top overwritten, count stays 2.
- Backpressure: a 3-move path with move_ready low for 4 cycles after each valid -> move_valid held high and move unchanged during each stall; exactly 3 handshakes; then replay again -> identical sequence.
- Empty/fail: done with sp=0, then run -> replay_done next cycle and move_valid never high. Separately, fail then run -> no valid, no replay_done, path_found=0.
- Overflow (DEPTH=4, ADDR_W=2): 5 pushes 0, 1, 2, 3, 1 -> overflow=1, count=4; done; replay -> 0, 1, 2, 3.
- Reset mid-replay: assert clear while move_valid=1 after 1 of 3 moves -> next cycle move_valid=0, count=0, state CAPTURE; a new push is accepted at buf[0].
